cmos_pixel_packer: RTL

Parametrised successor of the OV5640 8→16 bit converter. Packs BYTES_PER_PIX consecutive IN_W-bit camera bus beats into one pixel word, with selectable byte order. Each pixel is delayed one slot so that start-of-frame and end-of-line flags mark the correct pixel. Tracks line geometry and flags malformed lines. Sits directly behind the CMOS pins in the pclk domain, ahead of the CDC FIFO and frame writer.

---
 rtl/cmos_pkg.sv | 23 ++
 rtl/cmos_line_stats.sv | 56 +++++
 rtl/cmos_pixel_packer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cmos_pkg.sv
// Shared constants and helpers for the CMOS pixel packer.
// PIX_W and CNT_MAX describe the default build; parameterised modules
// derive their own widths from their parameters.
package cmos_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_BPP   = 2;
    localparam int DEF_CNT_W = 12;

    localparam int                   PIX_W   = DEF_IN_W * DEF_BPP;
    localparam logic [DEF_CNT_W-1:0] CNT_MAX = {DEF_CNT_W{1'b1}};

    // Low bit position of bus beat 'beat' inside a packed pixel word.
    function automatic int slice_lo(input int beat, input int bpp,
                                    input bit msb_first, input int in_w);
        if (msb_first) begin
            return (bpp - 1 - beat) * in_w;
        end else begin
            return beat * in_w;
        end
    endfunction

endpackage

// File: rtl/cmos_line_stats.sv
// Line geometry tracker: counts pixels per line and lines per frame,
// publishes the last line length and previous frame height, and pulses
// err_len when a line disagrees with the previous line of the same frame.
module cmos_line_stats
    import cmos_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             pixel_done,
    input  logic             line_end,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] frame_lines,
    output logic             err_len
);

    localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};

    logic [CNT_W-1:0] col_cnt_r;
    logic [CNT_W-1:0] line_cnt_r;

    // Column/line counting; frame start wins, and a pixel completing in the
    // frame-start cycle is already the first column of the new frame.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            col_cnt_r   <= {CNT_W{1'b0}};
            line_cnt_r  <= {CNT_W{1'b0}};
            line_len    <= {CNT_W{1'b0}};
            frame_lines <= {CNT_W{1'b0}};
            err_len     <= 1'b0;
        end else begin
            err_len <= 1'b0;
            if (frame_start) begin
                frame_lines <= line_cnt_r;
                line_cnt_r  <= {CNT_W{1'b0}};
                col_cnt_r   <= pixel_done ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
            end else if (line_end) begin
                line_len <= col_cnt_r;
                if ((line_cnt_r != {CNT_W{1'b0}}) && (col_cnt_r != line_len)) begin
                    err_len <= 1'b1;
                end
                if (line_cnt_r != CNT_TOP) begin
                    line_cnt_r <= line_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                col_cnt_r <= {CNT_W{1'b0}};
            end else if (pixel_done) begin
                if (col_cnt_r != CNT_TOP) begin
                    col_cnt_r <= col_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: rtl/cmos_pixel_packer.sv
// CMOS camera bus packer: assembles BYTES_PER_PIX bus beats into a pixel,
// holds each pixel one slot so the line's last pixel can carry eol, and
// reports malformed lines/frames. Lives entirely in the pclk domain.
module cmos_pixel_packer
    import cmos_pkg::*;
#(
    parameter int IN_W          = DEF_IN_W,
    parameter int BYTES_PER_PIX = DEF_BPP,
    parameter bit MSB_FIRST     = 1'b1,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                          pclk,
    input  logic                          rst,
    input  logic                          vs_i,
    input  logic                          de_i,
    input  logic [IN_W-1:0]               pdata_i,
    output logic                          pix_vld_o,
    output logic [IN_W*BYTES_PER_PIX-1:0] pix_data_o,
    output logic                          sof_o,
    output logic                          eol_o,
    output logic [CNT_W-1:0]              line_len_o,
    output logic [CNT_W-1:0]              frame_lines_o,
    output logic                          err_partial_o,
    output logic                          err_len_o
);

    localparam int         PW       = IN_W * BYTES_PER_PIX;
    localparam int         SLOTS    = (BYTES_PER_PIX > 1) ? BYTES_PER_PIX - 1 : 1;
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_PIX - 1);

    logic            vs_d_r;
    logic            de_d_r;
    logic            frame_act_r;
    logic            first_r;
    logic            pend_vld_r;
    logic [1:0]      beat_idx_r;
    logic [IN_W-1:0] slot_r [SLOTS];
    logic [PW-1:0]   pend_r;

    logic            frame_start_s;
    logic            de_eff_s;
    logic            line_end_s;
    logic [1:0]      cur_idx_s;
    logic            pixel_done_s;
    logic            stats_line_end_s;
    logic [PW-1:0]   word_s;

    // Edge detection; de is ignored until the first frame has started, and
    // a frame start restarts packing at beat 0.
    always_comb begin
        frame_start_s    = vs_i & ~vs_d_r;
        de_eff_s         = de_i & (frame_act_r | frame_start_s);
        line_end_s       = de_d_r & ~de_eff_s & ~frame_start_s;
        cur_idx_s        = frame_start_s ? 2'd0 : beat_idx_r;
        pixel_done_s     = de_eff_s & (cur_idx_s == LAST_IDX);
        stats_line_end_s = line_end_s & pend_vld_r;
    end

    // The final beat comes straight from the bus; earlier beats from slots.
    for (genvar g = 0; g < BYTES_PER_PIX; g++) begin : g_beat
        localparam int LO = slice_lo(g, BYTES_PER_PIX, MSB_FIRST, IN_W);
        if (g == BYTES_PER_PIX - 1) begin : g_last
            assign word_s[LO +: IN_W] = pdata_i;
        end else begin : g_slot
            assign word_s[LO +: IN_W] = slot_r[g];
        end
    end

    // Beat capture, pending-pixel stage, pixel/eol/sof strobes and partial-pixel error.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_d_r        <= 1'b0;
            de_d_r        <= 1'b0;
            frame_act_r   <= 1'b0;
            first_r       <= 1'b0;
            pend_vld_r    <= 1'b0;
            beat_idx_r    <= 2'd0;
            pend_r        <= {PW{1'b0}};
            pix_vld_o     <= 1'b0;
            pix_data_o    <= {PW{1'b0}};
            sof_o         <= 1'b0;
            eol_o         <= 1'b0;
            err_partial_o <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_r[i] <= {IN_W{1'b0}};
            end
        end else begin
            pix_vld_o     <= 1'b0;
            sof_o         <= 1'b0;
            eol_o         <= 1'b0;
            err_partial_o <= 1'b0;
            vs_d_r        <= vs_i;
            de_d_r        <= de_eff_s;
            if (frame_start_s) begin
                err_partial_o <= pend_vld_r | (beat_idx_r != 2'd0);
                pend_vld_r    <= 1'b0;
                first_r       <= 1'b1;
                frame_act_r   <= 1'b1;
                beat_idx_r    <= 2'd0;
            end
            if (de_eff_s) begin
                for (int i = 0; i < SLOTS; i++) begin
                    if ((cur_idx_s == 2'(i)) && !pixel_done_s) begin
                        slot_r[i] <= pdata_i;
                    end
                end
                if (pixel_done_s) begin
                    if (pend_vld_r && !frame_start_s) begin
                        pix_vld_o  <= 1'b1;
                        pix_data_o <= pend_r;
                        sof_o      <= first_r;
                        first_r    <= 1'b0;
                    end
                    pend_r     <= word_s;
                    pend_vld_r <= 1'b1;
                    beat_idx_r <= 2'd0;
                end else begin
                    beat_idx_r <= cur_idx_s + 2'd1;
                end
            end else if (line_end_s) begin
                if (pend_vld_r) begin
                    pix_vld_o  <= 1'b1;
                    pix_data_o <= pend_r;
                    sof_o      <= first_r;
                    eol_o      <= 1'b1;
                    first_r    <= 1'b0;
                end
                if (beat_idx_r != 2'd0) begin
                    err_partial_o <= 1'b1;
                end
                pend_vld_r <= 1'b0;
                beat_idx_r <= 2'd0;
            end
        end
    end

    cmos_line_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .pclk        (pclk),
        .rst         (rst),
        .frame_start (frame_start_s),
        .pixel_done  (pixel_done_s),
        .line_end    (stats_line_end_s),
        .line_len    (line_len_o),
        .frame_lines (frame_lines_o),
        .err_len     (err_len_o)
    );

endmodule
